// File: rtl/sdc_cmd_seq.sv
// SD card SPI command sequencer: sends a 6-byte command frame with CRC7 and polls for R1.
// Optional macro SDC_CMD_R7_EN adds resp_ext, the 4 trailing bytes of R3/R7 responses.
module sdc_cmd_seq #(
   parameter int NCR_MAX = 8,
   parameter bit FAST    = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  cmd_idx,
   input  logic [31:0] cmd_arg,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  r1,
`ifdef SDC_CMD_R7_EN
   output logic [31:0] resp_ext,
`endif
   output logic        stb,
   output logic        we,
   output logic        addr,
   output logic [7:0]  dout,
   input  logic [7:0]  din
);

   typedef enum logic [2:0] {S_IDLE, S_CS, S_PRE, S_FRAME, S_POLL, S_EXT, S_FIN, S_END} state_e;
   // Sub-phase of one byte transfer; P_NX is the stb-free cycle where the byte is consumed.
   typedef enum logic [2:0] {P_WR, P_G1, P_ST, P_G2, P_RD, P_NX} phase_e;

   localparam logic [7:0] NCR_LIM = 8'(NCR_MAX);

   state_e      state_q, state_d;
   phase_e      ph_q, ph_d;
   logic [5:0]  cmd_q, cmd_d;
   logic [31:0] arg_q, arg_d;
   logic [6:0]  crc_q, crc_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  r1sh_q, r1sh_d;
   logic        tosh_q, tosh_d;
   logic        busy_q, busy_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  r1_q, r1_d;
   logic [7:0]  tx;
`ifdef SDC_CMD_R7_EN
   logic [31:0] extsh_q, extsh_d;
   logic [31:0] ext_q, ext_d;
   assign resp_ext = ext_q;
`endif

   assign busy    = busy_q;
   assign timeout = timeout_q;
   assign r1      = r1_q;

   function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
      logic [6:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[6] ^ b[i];
         r  = {r[5:0], 1'b0};
         if (fb) r = r ^ 7'h09;
      end
      return r;
   endfunction

   always_comb begin
      tx = 8'hFF;
      if (state_q == S_FRAME) begin
         case (bcnt_q)
            3'd0:    tx = {2'b01, cmd_q};
            3'd1:    tx = arg_q[31:24];
            3'd2:    tx = arg_q[23:16];
            3'd3:    tx = arg_q[15:8];
            3'd4:    tx = arg_q[7:0];
            3'd5:    tx = {crc_q, 1'b1};
            default: tx = 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ph_q      <= P_WR;
         cmd_q     <= '0;
         arg_q     <= '0;
         crc_q     <= '0;
         bcnt_q    <= '0;
         pcnt_q    <= '0;
         rx_q      <= 8'hFF;
         r1sh_q    <= 8'hFF;
         tosh_q    <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         r1_q      <= 8'hFF;
`ifdef SDC_CMD_R7_EN
         extsh_q   <= '0;
         ext_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         cmd_q     <= cmd_d;
         arg_q     <= arg_d;
         crc_q     <= crc_d;
         bcnt_q    <= bcnt_d;
         pcnt_q    <= pcnt_d;
         rx_q      <= rx_d;
         r1sh_q    <= r1sh_d;
         tosh_q    <= tosh_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         r1_q      <= r1_d;
`ifdef SDC_CMD_R7_EN
         extsh_q   <= extsh_d;
         ext_q     <= ext_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      cmd_d     = cmd_q;
      arg_d     = arg_q;
      crc_d     = crc_q;
      bcnt_d    = bcnt_q;
      pcnt_d    = pcnt_q;
      rx_d      = rx_q;
      r1sh_d    = r1sh_q;
      tosh_d    = tosh_q;
      busy_d    = busy_q;
      timeout_d = timeout_q;
      r1_d      = r1_q;
`ifdef SDC_CMD_R7_EN
      extsh_d   = extsh_q;
      ext_d     = ext_q;
`endif
      stb  = 1'b0;
      we   = 1'b0;
      addr = 1'b0;
      dout = 8'h00;
      done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cmd_d     = cmd_idx;
               arg_d     = cmd_arg;
               crc_d     = '0;
               bcnt_d    = '0;
               pcnt_d    = 8'd1;
               r1sh_d    = 8'hFF;
               tosh_d    = 1'b0;
               busy_d    = 1'b1;
               timeout_d = 1'b0;
`ifdef SDC_CMD_R7_EN
               extsh_d   = '0;
`endif
               ph_d      = P_WR;
               state_d   = S_CS;
            end
         end
         S_CS: begin
            if (ph_q == P_WR) begin
               stb  = 1'b1;
               we   = 1'b1;
               dout = {6'b0, FAST, 1'b1};
               ph_d = P_NX;
            end else begin
               ph_d    = P_WR;
               state_d = S_PRE;
            end
         end
         S_END: begin
            done    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            case (ph_q)
               P_WR: begin
                  stb  = 1'b1;
                  we   = 1'b1;
                  addr = 1'b1;
                  dout = tx;
                  // CRC covers only the five bytes ahead of the CRC byte itself.
                  if (state_q == S_FRAME && bcnt_q < 3'd5) crc_d = crc7_upd(crc_q, tx);
                  ph_d = P_G1;
               end
               P_G1: ph_d = P_ST;
               P_ST: begin
                  stb  = 1'b1;
                  ph_d = din[0] ? P_G2 : P_G1;
               end
               P_G2: ph_d = P_RD;
               P_RD: begin
                  stb  = 1'b1;
                  addr = 1'b1;
                  rx_d = din;
                  ph_d = P_NX;
               end
               default: begin
                  ph_d = P_WR;
                  case (state_q)
                     S_PRE: begin
                        bcnt_d  = '0;
                        state_d = S_FRAME;
                     end
                     S_FRAME: begin
                        if (bcnt_q == 3'd5) state_d = S_POLL;
                        else                bcnt_d  = bcnt_q + 3'd1;
                     end
                     S_POLL: begin
                        if (!rx_q[7]) begin
                           r1sh_d  = rx_q;
                           state_d = S_FIN;
`ifdef SDC_CMD_R7_EN
                           if (!rx_q[2] && (cmd_q == 6'd8 || cmd_q == 6'd58)) begin
                              bcnt_d  = '0;
                              state_d = S_EXT;
                           end
`endif
                        end else if (pcnt_q == NCR_LIM) begin
                           r1sh_d  = 8'hFF;
                           tosh_d  = 1'b1;
                           state_d = S_FIN;
                        end else begin
                           pcnt_d = pcnt_q + 8'd1;
                        end
                     end
`ifdef SDC_CMD_R7_EN
                     S_EXT: begin
                        extsh_d = {extsh_q[23:0], rx_q};
                        if (bcnt_q == 3'd3) state_d = S_FIN;
                        else                bcnt_d  = bcnt_q + 3'd1;
                     end
`endif
                     S_FIN: begin
                        // Results become visible together with done.
                        r1_d      = r1sh_q;
                        timeout_d = tosh_q;
`ifdef SDC_CMD_R7_EN
                        ext_d     = extsh_q;
`endif
                        state_d   = S_END;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_sdc_cmd_seq.sv
// Self-checking bench for sdc_cmd_seq with a behavioural SPI byte controller and SD card model.
module tb_sdc_cmd_seq;

   localparam int NCR = 8;
   localparam int LAT = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  cmd_idx = '0;
   logic [31:0] cmd_arg = '0;
   logic        busy, done, timeout, stb, we, addr;
   logic [7:0]  r1, dout, din;
`ifdef SDC_CMD_R7_EN
   logic [31:0] resp_ext;
`endif

   int checks = 0;
   int failures = 0;

   sdc_cmd_seq #(.NCR_MAX(NCR), .FAST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
      .busy(busy), .done(done), .timeout(timeout), .r1(r1),
`ifdef SDC_CMD_R7_EN
      .resp_ext(resp_ext),
`endif
      .stb(stb), .we(we), .addr(addr), .dout(dout), .din(din));

   always #5 clk = ~clk;

   // Controller + card model
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   logic [7:0] miso_q[$];
   logic       ready_r;
   logic [7:0] rx_r;
   int         lat_cnt;
   logic       prev_stb;
   int         proto_err = 0;
   int         ctrl_wr = 0;
   int         done_cnt = 0;

   assign din = addr ? rx_r : {7'b0, ready_r};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r  <= 1'b0;
         rx_r     <= 8'hFF;
         lat_cnt  <= 0;
         prev_stb <= 1'b0;
      end else begin
         logic [7:0] t;
         prev_stb <= stb;
         if (done) done_cnt++;
         if (stb && prev_stb) proto_err++;
         if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
               t = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
               ready_r <= 1'b1;
               rx_r    <= t;
            end
         end
         if (stb && we && addr) begin
            if (lat_cnt != 0 || ready_r) proto_err++;
            obs_q.push_back(dout);
            lat_cnt <= LAT;
            ready_r <= 1'b0;
         end
         if (stb && !we && addr) begin
            if (!ready_r) proto_err++;
            ready_r <= 1'b0;
         end
         if (stb && we && !addr) begin
            ctrl_wr++;
            if (dout !== 8'h01) proto_err++;
         end
      end
   end

   function automatic logic [6:0] crc7_ref(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb);
      exp_q.push_back(8'hFF);
      exp_q.push_back({2'b01, idx});
      exp_q.push_back(arg[31:24]);
      exp_q.push_back(arg[23:16]);
      exp_q.push_back(arg[15:8]);
      exp_q.push_back(arg[7:0]);
      exp_q.push_back(crcb);
   endtask

   task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg);
      @(negedge clk);
      cmd_idx = idx;
      cmd_arg = arg;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (done) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      obs_q.delete();
      miso_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, timeout, stb, we, addr} !== 6'b0) begin failures++;
         $display("FAIL reset_ctl got=%b want=000000", {busy, done, timeout, stb, we, addr}); end
      checks++; if (r1 !== 8'hFF) begin failures++; $display("FAIL reset_r1 got=%h want=ff", r1); end
      checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h want=00", dout); end
`ifdef SDC_CMD_R7_EN
      checks++; if (resp_ext !== 32'h0) begin failures++; $display("FAIL reset_ext got=%h want=0", resp_ext); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cmd0();
      bit ok; int d0, c0, p0;
      clear_model();
      push_frame(6'd0, 32'h0, 8'h95);
      repeat (3) exp_q.push_back(8'hFF);
      repeat (7) miso_q.push_back(8'hFF);
      miso_q.push_back(8'hFF); miso_q.push_back(8'h01);
      d0 = done_cnt; c0 = ctrl_wr; p0 = proto_err;
      pulse_start(6'd0, 32'h0);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL cmd0_done got=timeout want=done"); end
      checks++; if (r1 !== 8'h01) begin failures++; $display("FAIL cmd0_r1 got=%h want=01", r1); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL cmd0_to got=%b want=0", timeout); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin failures++;
         $display("FAIL cmd0_pulse got=done%b busy%b n=%0d want=0 0 1", done, busy, done_cnt - d0); end
      checks++; if (obs_q.size() != exp_q.size()) begin failures++;
         $display("FAIL cmd0_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [7:0] o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL cmd0_mosi got=%h want=%h", o, e); end
      end
      checks++; if (ctrl_wr - c0 != 1 || proto_err != p0) begin failures++;
         $display("FAIL cmd0_bus got=ctrl%0d err%0d want=ctrl1 err0", ctrl_wr - c0, proto_err - p0); end
   endtask

   task automatic test_cmd8();
      bit ok;
      clear_model();
      push_frame(6'd8, 32'h0000_01AA, 8'h87);
      exp_q.push_back(8'hFF);
`ifdef SDC_CMD_R7_EN
      repeat (4) exp_q.push_back(8'hFF);
`endif
      exp_q.push_back(8'hFF);
      repeat (7) miso_q.push_back(8'hFF);
      miso_q.push_back(8'h01); miso_q.push_back(8'h00); miso_q.push_back(8'h00);
      miso_q.push_back(8'h01); miso_q.push_back(8'hAA);
      pulse_start(6'd8, 32'h0000_01AA);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL cmd8_done got=timeout want=done"); end
      checks++; if (r1 !== 8'h01) begin failures++; $display("FAIL cmd8_r1 got=%h want=01", r1); end
`ifdef SDC_CMD_R7_EN
      checks++; if (resp_ext !== 32'h0000_01AA) begin failures++;
         $display("FAIL cmd8_ext got=%h want=000001aa", resp_ext); end
`endif
      @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++;
         $display("FAIL cmd8_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [7:0] o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL cmd8_mosi got=%h want=%h", o, e); end
      end
   endtask

   task automatic test_timeout();
      bit ok; int p0;
      clear_model();
      push_frame(6'd1, 32'h0, {crc7_ref({8'h41, 32'h0}), 1'b1});
      repeat (NCR + 1) exp_q.push_back(8'hFF);
      p0 = proto_err;
      pulse_start(6'd1, 32'h0);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL to_done got=timeout want=done"); end
      checks++; if (r1 !== 8'hFF || timeout !== 1'b1) begin failures++;
         $display("FAIL to_result got=r1 %h to %b want=ff 1", r1, timeout); end
      @(negedge clk);
      checks++; if (obs_q.size() != 7 + NCR + 1) begin failures++;
         $display("FAIL to_len got=%0d want=%0d", obs_q.size(), 7 + NCR + 1); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [7:0] o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL to_mosi got=%h want=%h", o, e); end
      end
      checks++; if (proto_err != p0) begin failures++; $display("FAIL to_bus got=%0d want=0", proto_err - p0); end
   endtask

   task automatic test_busy_ignore();
      bit ok; int d0, p0;
      clear_model();
      push_frame(6'd13, 32'h0, {crc7_ref({8'h4D, 32'h0}), 1'b1});
      repeat (2) exp_q.push_back(8'hFF);
      repeat (7) miso_q.push_back(8'hFF);
      miso_q.push_back(8'h00);
      d0 = done_cnt; p0 = proto_err;
      pulse_start(6'd13, 32'h0);
      checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin failures++;
         $display("FAIL busy_accept got=busy%b to%b want=1 0", busy, timeout); end
      repeat (30) @(negedge clk);
      pulse_start(6'd2, 32'hDEAD_BEEF);
      wait_done(ok);
      checks++; if (!ok || r1 !== 8'h00) begin failures++;
         $display("FAIL busy_r1 got=%h ok%b want=00 1", r1, ok); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || done_cnt - d0 != 1 || proto_err != p0) begin failures++;
         $display("FAIL busy_ignore got=busy%b n=%0d err%0d want=0 1 0", busy, done_cnt - d0, proto_err - p0); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [7:0] o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL busy_mosi got=%h want=%h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int d0;
      clear_model();
      d0 = done_cnt;
      pulse_start(6'd24, 32'h0000_0200);
      for (int i = 0; i < 2000 && obs_q.size() < 3; i++) @(negedge clk);
      checks++; if (obs_q.size() < 3) begin failures++; $display("FAIL mid_reach got=%0d want=3", obs_q.size()); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy, done, timeout, stb, we, addr} !== 6'b0 || r1 !== 8'hFF || dout !== 8'h00) begin failures++;
         $display("FAIL mid_reset got=%b r1 %h dout %h want=000000 ff 00", {busy, done, timeout, stb, we, addr}, r1, dout); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (done_cnt != d0 || busy !== 1'b0) begin failures++;
         $display("FAIL mid_nodone got=%0d busy%b want=0 0", done_cnt - d0, busy); end
      clear_model();
      push_frame(6'd17, 32'h1234_5678, {crc7_ref({8'h51, 32'h1234_5678}), 1'b1});
      repeat (4) exp_q.push_back(8'hFF);
      repeat (9) miso_q.push_back(8'hFF);
      miso_q.push_back(8'h00);
      pulse_start(6'd17, 32'h1234_5678);
      wait_done(ok);
      checks++; if (!ok || r1 !== 8'h00 || timeout !== 1'b0) begin failures++;
         $display("FAIL cmd17_r1 got=%h to%b ok%b want=00 0 1", r1, timeout, ok); end
      @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++;
         $display("FAIL cmd17_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [7:0] o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL cmd17_mosi got=%h want=%h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd8();
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
